// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler processor: widths and the fetch/execute
// phase encoding used by both the program sequencer and the fetch stage.
package nibbler_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int BYTE_W     = 8;
  localparam int NIBBLE_W   = 4;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

endpackage

// File: rtl/program_mem.sv
// Program store: 2**ADDR_W bytes, synchronous write from the loader and a
// registered read port that becomes the sequencer's programByte output.
module program_mem
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [BYTE_W-1:0] o_rd_data
);

  logic [BYTE_W-1:0] r_mem [2**ADDR_W];
  logic [BYTE_W-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto RAM and keeps its program across reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute phase sequencer with program counter and halted-mode loader.
// Optional loader checksum register enabled by defining SEQ_CHECKSUM_EN.
module program_sequencer
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] programByte,
  output logic              phase,
  output logic [ADDR_W-1:0] pc,
  output logic [BYTE_W-1:0] checksum
);

  phase_t            r_phase;
  phase_t            w_phase_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_fetch;
  logic              w_wr_en;

  // Loader is only served while halted, so writes never race a fetch.
  assign wr_ready = ~run & ~reset;
  assign w_wr_en  = wr_valid & wr_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_phase_next = r_phase;
    w_pc_next    = r_pc;
    w_fetch      = 1'b0;
    if (run) begin
      case (r_phase)
        PH_FETCH: begin
          w_fetch      = 1'b1;
          w_phase_next = PH_EXEC;
        end
        PH_EXEC: begin
          w_phase_next = PH_FETCH;
          w_pc_next    = load_pc ? jump_addr : r_pc + 1'b1;
        end
        default: w_phase_next = PH_FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_FETCH;
      r_pc    <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_pc    <= w_pc_next;
    end
  end

  program_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_fetch),
    .i_rd_addr (r_pc),
    .o_rd_data (programByte)
  );

`ifdef SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_checksum <= '0;
    else if (w_wr_en) r_checksum <= r_checksum ^ wr_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign phase = r_phase;
  assign pc    = r_pc;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a byte-array program model is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_program_sequencer;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          load_pc = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [7:0]    programByte;
  logic          phase;
  logic [AW-1:0] pc;
  logic [7:0]    checksum;

  int n_pass  = 0;
  int n_total = 0;
  bit compare_on = 1'b0;

  program_sequencer #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .load_pc     (load_pc),
    .jump_addr   (jump_addr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .programByte (programByte),
    .phase       (phase),
    .pc          (pc),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  // Behavioural model: program bytes, instruction pointer, alternating phase.
  logic [7:0]    m_mem [4096];
  bit            m_known [4096];
  int            m_pc = 0;
  bit            m_exec = 1'b0;
  logic [7:0]    m_pb = 8'h00;
  bit            m_pb_known = 1'b1;
  logic [7:0]    m_sum = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc       <= 0;
      m_exec     <= 1'b0;
      m_pb       <= 8'h00;
      m_pb_known <= 1'b1;
      m_sum      <= 8'h00;
    end else begin
      if (run) begin
        if (!m_exec) begin
          m_pb       <= m_mem[m_pc];
          m_pb_known <= m_known[m_pc];
        end else begin
          m_pc <= load_pc ? int'(jump_addr) : (m_pc + 1) % 4096;
        end
        m_exec <= !m_exec;
      end else if (wr_valid) begin
        m_mem[int'(wr_addr)]   <= wr_data;
        m_known[int'(wr_addr)] <= 1'b1;
`ifdef SEQ_CHECKSUM_EN
        m_sum <= m_sum ^ wr_data;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      check("cyc_phase", 32'(phase), 32'(m_exec));
      check("cyc_pc", 32'(pc), 32'(m_pc));
      check("cyc_wr_ready", 32'(wr_ready), 32'(!run && !reset));
      check("cyc_checksum", 32'(checksum), 32'(m_sum));
      if (m_pb_known) check("cyc_programByte", 32'(programByte), 32'(m_pb));
    end
  end

  // One clock: apply inputs, take the edge, settle just after it.
  task automatic cyc(input logic r, input logic ld, input logic [AW-1:0] ja,
                     input logic wv, input logic [AW-1:0] wa, input logic [7:0] wd);
    run = r; load_pc = ld; jump_addr = ja;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, '0, 1'b1, a, d);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_pb", 32'(programByte), 32'h00);
    check("rst_sum", 32'(checksum), 32'h00);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    compare_on = 1'b1;
    #1 check("halt_wr_ready", 32'(wr_ready), 32'd1);

    // Load program while halted
    wr(12'h000, 8'h3C);
    wr(12'h001, 8'hF0);
    wr(12'h002, 8'h77);
    wr(12'h005, 8'h99);
    wr(12'h0A5, 8'h5A);
    wr(12'hFFF, 8'hE1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);
    check("halt_hold_pc", 32'(pc), 32'd0);

    // Basic fetch/execute sequence
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("f0_pb", 32'(programByte), 32'h3C);
    check("f0_phase", 32'(phase), 32'd1);
    check("f0_pc", 32'(pc), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("e0_pc", 32'(pc), 32'd1);
    check("e0_phase", 32'(phase), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("f1_pb", 32'(programByte), 32'hF0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);

    // load_pc during fetch ignored, during execute honoured
    cyc(1'b1, 1'b1, 12'h0A5, 1'b0, '0, '0);
    check("fetch_ld_ignored_pc", 32'(pc), 32'd2);
    check("f2_pb", 32'(programByte), 32'h77);
    cyc(1'b1, 1'b1, 12'h0A5, 1'b0, '0, '0);
    check("jump_pc", 32'(pc), 32'h0A5);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("jump_pb", 32'(programByte), 32'h5A);

    // Wrap from all-ones
    cyc(1'b1, 1'b1, 12'hFFF, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("fff_pb", 32'(programByte), 32'hE1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("wrap_pc", 32'(pc), 32'h000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("wrap_pb", 32'(programByte), 32'h3C);

    // Loader blocked while running, accepted once halted
    cyc(1'b1, 1'b0, '0, 1'b1, 12'h001, 8'hAB);
    check("run_wr_ready", 32'(wr_ready), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b1, 12'h001, 8'hAB);
    check("blocked_pb", 32'(programByte), 32'hF0);
    cyc(1'b1, 1'b0, '0, 1'b1, 12'h001, 8'hAB);
    wr(12'h001, 8'hAB);
    wr(12'h002, 8'hCD);
    check("no_bypass_pb", 32'(programByte), 32'hF0);
    check("halted_pc", 32'(pc), 32'd2);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("new_byte_pb", 32'(programByte), 32'hCD);
    cyc(1'b1, 1'b1, 12'h001, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("accepted_pb", 32'(programByte), 32'hAB);

    // Async reset in execute at pc=5
    cyc(1'b1, 1'b1, 12'h005, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("pre_rst_pc", 32'(pc), 32'd5);
    check("pre_rst_phase", 32'(phase), 32'd1);
    check("pre_rst_pb", 32'(programByte), 32'h99);
    #2 reset = 1'b1;
    #1;
    check("async_phase", 32'(phase), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    check("async_pb", 32'(programByte), 32'h00);
    check("async_wr_ready", 32'(wr_ready), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("retained_pb", 32'(programByte), 32'h3C);

    // Checksum after a fresh reset
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    #1 reset = 1'b0;
    wr(12'h010, 8'h0F);
    wr(12'h011, 8'hF0);
    wr(12'h012, 8'h3C);
`ifdef SEQ_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'hC3);
`else
    check("checksum", 32'(checksum), 32'h00);
`endif
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);

    compare_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
